// File: rtl/pedestal_filter_config_sequencer.sv
// pedestal_filter_config_sequencer
// Sequences the HPF/LPF pedestal-recovery filter bank. It pulses the filter
// reset, loads three coefficient words over the shared coefficient/reg_select
// bus, then gates the filter enable. A settle counter reports when the filter
// outputs are valid after a load.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   en                  filter run request from the datapath
//   cfg_req             reconfiguration request (level, held until accepted)
//   cfg_hpf_sel         HPF cutoff index 0..4 (5..7 rejected with cfg_err)
//   cfg_lpf_en          1 = load LPF table, 0 = LPF bypass (zero coefficients)
//   cfg_ready           request accepted this cycle if cfg_req=1
//   cfg_done            1-cycle pulse when a load completes
//   cfg_err             1-cycle pulse when an invalid request is accepted
//   filt_reset          filter reset
//   filt_reg_select     filter coefficient word select
//   filt_load           filter coefficient load strobe
//   hpf_coefficient     HPF coefficient word
//   lpf_coefficient     LPF coefficient word
//   filt_en             filter enable (combinational on en)
//   settled             filter outputs valid
module pedestal_filter_config_sequencer #(
    parameter int unsigned HPF_SEL_DEFAULT = 0,
    parameter int unsigned LPF_EN_DEFAULT  = 0,
    parameter int unsigned SETTLE_CYCLES   = 1024,
    parameter int unsigned CNT_W           = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        cfg_req,
    input  logic [2:0]  cfg_hpf_sel,
    input  logic        cfg_lpf_en,
    output logic        cfg_ready,
    output logic        cfg_done,
    output logic        cfg_err,
    output logic        filt_reset,
    output logic [1:0]  filt_reg_select,
    output logic        filt_load,
    output logic [31:0] hpf_coefficient,
    output logic [31:0] lpf_coefficient,
    output logic        filt_en,
    output logic        settled
);

    localparam int unsigned COEF_W = 32;

    localparam logic [2:0] S_FRST  = 3'd0;
    localparam logic [2:0] S_LD0   = 3'd1;
    localparam logic [2:0] S_LD1   = 3'd2;
    localparam logic [2:0] S_LD2   = 3'd3;
    localparam logic [2:0] S_RUN   = 3'd4;
    localparam logic [2:0] S_PAUSE = 3'd5;

    localparam logic [2:0]       SEL_MAX    = 3'd4;
    localparam logic [CNT_W-1:0] SETTLE_MAX = CNT_W'(SETTLE_CYCLES);

    // HPF coefficient table lookup: word idx 0..2 for the given cutoff index
    function automatic logic [COEF_W-1:0] hpf_word(input logic [2:0] sel, input logic [1:0] idx);
        logic [COEF_W-1:0] w;
        w = '0;
        case ({sel, idx})
            5'b000_00: w = 32'h0000FF00;
            5'b000_01: w = 32'hFFFF0100;
            5'b000_10: w = 32'h0000FE07;
            5'b001_00: w = 32'h0000FCF4;
            5'b001_01: w = 32'hFFFF030C;
            5'b001_10: w = 32'h0000F9E1;
            5'b010_00: w = 32'h0000F9F5;
            5'b010_01: w = 32'hFFFF060B;
            5'b010_10: w = 32'h0000F3EA;
            5'b011_00: w = 32'h0000F168;
            5'b011_01: w = 32'hFFFF0E98;
            5'b011_10: w = 32'h0000E2CA;
            5'b100_00: w = 32'h0000E546;
            5'b100_01: w = 32'hFFFF1ABA;
            5'b100_10: w = 32'h0000CA92;
            default:   w = '0;
        endcase
        return w;
    endfunction

    // LPF coefficient table lookup (single table, bypass handled by caller)
    function automatic logic [COEF_W-1:0] lpf_word(input logic [1:0] idx);
        logic [COEF_W-1:0] w;
        case (idx)
            2'd0:    w = 32'h0000001F;
            2'd1:    w = 32'h0000001F;
            2'd2:    w = 32'h0000FFBE;
            default: w = '0;
        endcase
        return w;
    endfunction

    logic [2:0]        state_q, state_d;
    logic [2:0]        sel_q, sel_d;
    logic              lpf_en_q, lpf_en_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              cfg_ready_q, cfg_ready_d;
    logic              cfg_done_q, cfg_done_d;
    logic              cfg_err_q, cfg_err_d;
    logic              filt_reset_q, filt_reset_d;
    logic [1:0]        filt_reg_select_q, filt_reg_select_d;
    logic              filt_load_q, filt_load_d;
    logic [COEF_W-1:0] hpf_coefficient_q, hpf_coefficient_d;
    logic [COEF_W-1:0] lpf_coefficient_q, lpf_coefficient_d;
    logic              settled_q, settled_d;

    // Enable follows en directly so the datapath sees no extra latency
    assign filt_en = (state_q == S_RUN) & en;

    // Next state, latched configuration and settle counter
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        lpf_en_d   = lpf_en_q;
        cnt_d      = cnt_q;
        cfg_done_d = 1'b0;
        cfg_err_d  = 1'b0;
        case (state_q)
            S_FRST: begin
                state_d = S_LD0;
                cnt_d   = '0;
            end
            S_LD0: state_d = S_LD1;
            S_LD1: state_d = S_LD2;
            S_LD2: begin
                state_d    = en ? S_RUN : S_PAUSE;
                cfg_done_d = 1'b1;
            end
            S_RUN, S_PAUSE: begin
                // An accepted request, valid or not, freezes the run/pause move and counter
                if (cfg_req) begin
                    if (cfg_hpf_sel <= SEL_MAX) begin
                        state_d  = S_FRST;
                        sel_d    = cfg_hpf_sel;
                        lpf_en_d = cfg_lpf_en;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end else begin
                    state_d = en ? S_RUN : S_PAUSE;
                    if (filt_en && (cnt_q < SETTLE_MAX)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = S_FRST;
        endcase
    end

    // Moore output decode, taken from the next state so outputs can be registered
    always_comb begin
        cfg_ready_d       = (state_d == S_RUN) || (state_d == S_PAUSE);
        filt_reset_d      = (state_d == S_FRST);
        filt_load_d       = 1'b0;
        filt_reg_select_d = 2'd0;
        hpf_coefficient_d = '0;
        lpf_coefficient_d = '0;
        settled_d         = cfg_ready_d && (cnt_d == SETTLE_MAX);
        if ((state_d == S_LD0) || (state_d == S_LD1) || (state_d == S_LD2)) begin
            filt_load_d       = 1'b1;
            filt_reg_select_d = 2'(state_d - S_LD0);
            hpf_coefficient_d = hpf_word(sel_d, filt_reg_select_d);
            lpf_coefficient_d = lpf_en_d ? lpf_word(filt_reg_select_d) : '0;
        end
    end

    // State and output registers; reset values match the FRST decode
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= S_FRST;
            sel_q             <= 3'(HPF_SEL_DEFAULT);
            lpf_en_q          <= 1'(LPF_EN_DEFAULT);
            cnt_q             <= '0;
            cfg_ready_q       <= 1'b0;
            cfg_done_q        <= 1'b0;
            cfg_err_q         <= 1'b0;
            filt_reset_q      <= 1'b1;
            filt_reg_select_q <= 2'd0;
            filt_load_q       <= 1'b0;
            hpf_coefficient_q <= '0;
            lpf_coefficient_q <= '0;
            settled_q         <= 1'b0;
        end else begin
            state_q           <= state_d;
            sel_q             <= sel_d;
            lpf_en_q          <= lpf_en_d;
            cnt_q             <= cnt_d;
            cfg_ready_q       <= cfg_ready_d;
            cfg_done_q        <= cfg_done_d;
            cfg_err_q         <= cfg_err_d;
            filt_reset_q      <= filt_reset_d;
            filt_reg_select_q <= filt_reg_select_d;
            filt_load_q       <= filt_load_d;
            hpf_coefficient_q <= hpf_coefficient_d;
            lpf_coefficient_q <= lpf_coefficient_d;
            settled_q         <= settled_d;
        end
    end

    assign cfg_ready       = cfg_ready_q;
    assign cfg_done        = cfg_done_q;
    assign cfg_err         = cfg_err_q;
    assign filt_reset      = filt_reset_q;
    assign filt_reg_select = filt_reg_select_q;
    assign filt_load       = filt_load_q;
    assign hpf_coefficient = hpf_coefficient_q;
    assign lpf_coefficient = lpf_coefficient_q;
    assign settled         = settled_q;

endmodule

// File: tb/tb_pedestal_filter_config_sequencer.sv
// Testbench for pedestal_filter_config_sequencer: directed scenarios with
// literal expectations followed by random traffic, all checked every cycle
// against a phase-based behavioural model.
module tb_pedestal_filter_config_sequencer;

    localparam int S = 8;

    logic        clk;
    logic        reset;
    logic        en;
    logic        cfg_req;
    logic [2:0]  cfg_hpf_sel;
    logic        cfg_lpf_en;
    logic        cfg_ready;
    logic        cfg_done;
    logic        cfg_err;
    logic        filt_reset;
    logic [1:0]  filt_reg_select;
    logic        filt_load;
    logic [31:0] hpf_coefficient;
    logic [31:0] lpf_coefficient;
    logic        filt_en;
    logic        settled;

    pedestal_filter_config_sequencer #(
        .HPF_SEL_DEFAULT(0),
        .LPF_EN_DEFAULT (0),
        .SETTLE_CYCLES  (S),
        .CNT_W          (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .en             (en),
        .cfg_req        (cfg_req),
        .cfg_hpf_sel    (cfg_hpf_sel),
        .cfg_lpf_en     (cfg_lpf_en),
        .cfg_ready      (cfg_ready),
        .cfg_done       (cfg_done),
        .cfg_err        (cfg_err),
        .filt_reset     (filt_reset),
        .filt_reg_select(filt_reg_select),
        .filt_load      (filt_load),
        .hpf_coefficient(hpf_coefficient),
        .lpf_coefficient(lpf_coefficient),
        .filt_en        (filt_en),
        .settled        (settled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] HPF_TAB [15] = '{
        32'h0000FF00, 32'hFFFF0100, 32'h0000FE07,
        32'h0000FCF4, 32'hFFFF030C, 32'h0000F9E1,
        32'h0000F9F5, 32'hFFFF060B, 32'h0000F3EA,
        32'h0000F168, 32'hFFFF0E98, 32'h0000E2CA,
        32'h0000E546, 32'hFFFF1ABA, 32'h0000CA92
    };
    localparam logic [31:0] LPF_TAB [3] = '{32'h0000001F, 32'h0000001F, 32'h0000FFBE};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase -1 = configured (run/pause), 0 = filter reset, 1..3 = word loads
    int m_phase = 0;
    bit m_run   = 1'b0;
    int m_sel   = 0;
    bit m_lpf   = 1'b0;
    int m_count = 0;
    bit m_done  = 1'b0;
    bit m_err   = 1'b0;
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_phase = 0;
            m_sel   = 0;
            m_lpf   = 1'b0;
            m_count = 0;
            m_done  = 1'b0;
            m_err   = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_done = 1'b0;
            m_err  = 1'b0;
            if (m_phase < 0) begin
                if (cfg_req) begin
                    if (int'(cfg_hpf_sel) <= 4) begin
                        m_sel   = int'(cfg_hpf_sel);
                        m_lpf   = cfg_lpf_en;
                        m_phase = 0;
                        m_count = 0;
                    end else begin
                        m_err = 1'b1;
                    end
                end else begin
                    if (m_run && en && m_count < S) m_count++;
                    m_run = en;
                end
            end else if (m_phase == 3) begin
                m_phase = -1;
                m_run   = en;
                m_done  = 1'b1;
            end else begin
                m_phase++;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (m_valid) begin
            bit          idle;
            bit          ld;
            logic [31:0] e_hpf;
            logic [31:0] e_lpf;
            idle  = (m_phase < 0);
            ld    = (m_phase >= 1);
            e_hpf = ld ? HPF_TAB[m_sel*3 + m_phase - 1] : 32'h0;
            e_lpf = (ld && m_lpf) ? LPF_TAB[m_phase - 1] : 32'h0;
            check("m_filt_reset", 32'(filt_reset), 32'(m_phase == 0));
            check("m_filt_load", 32'(filt_load), 32'(ld));
            check("m_reg_select", 32'(filt_reg_select), ld ? 32'(m_phase - 1) : 32'h0);
            check("m_hpf", hpf_coefficient, e_hpf);
            check("m_lpf", lpf_coefficient, e_lpf);
            check("m_cfg_ready", 32'(cfg_ready), 32'(idle));
            check("m_filt_en", 32'(filt_en), 32'(idle && m_run && en));
            check("m_settled", 32'(settled), 32'(idle && m_count == S));
            check("m_cfg_done", 32'(cfg_done), 32'(m_done));
            check("m_cfg_err", 32'(cfg_err), 32'(m_err));
        end
    end

    initial begin
        reset       = 1'b1;
        en          = 1'b1;
        cfg_req     = 1'b0;
        cfg_hpf_sel = 3'd0;
        cfg_lpf_en  = 1'b0;
        repeat (2) @(posedge clk);

        // Reset and default load
        @(negedge clk);
        check("rst_filt_reset", 32'(filt_reset), 32'd1);
        check("rst_ready", 32'(cfg_ready), 32'd0);
        check("rst_load", 32'(filt_load), 32'd0);
        check("rst_hpf", hpf_coefficient, 32'h0);
        #1 reset = 1'b0;
        @(negedge clk);
        check("t1_ld0_hpf", hpf_coefficient, 32'h0000FF00);
        check("t1_ld0_sel", 32'(filt_reg_select), 32'd0);
        check("t1_ld0_load", 32'(filt_load), 32'd1);
        check("t1_ld0_lpf", lpf_coefficient, 32'h0);
        @(negedge clk);
        check("t1_ld1_hpf", hpf_coefficient, 32'hFFFF0100);
        check("t1_ld1_sel", 32'(filt_reg_select), 32'd1);
        @(negedge clk);
        check("t1_ld2_hpf", hpf_coefficient, 32'h0000FE07);
        check("t1_ld2_sel", 32'(filt_reg_select), 32'd2);
        @(negedge clk);
        check("t1_done", 32'(cfg_done), 32'd1);
        check("t1_filt_en", 32'(filt_en), 32'd1);
        check("t1_ready", 32'(cfg_ready), 32'd1);
        check("t1_settled", 32'(settled), 32'd0);

        // Settle counting with a pause in the middle: 4 + 4 enabled cycles
        repeat (4) @(negedge clk);
        #1 en = 1'b0;
        repeat (3) @(negedge clk);
        check("t4_pause_settled", 32'(settled), 32'd0);
        check("t4_pause_filt_en", 32'(filt_en), 32'd0);
        check("t4_pause_ready", 32'(cfg_ready), 32'd1);
        #1 en = 1'b1;
        repeat (4) @(negedge clk);
        check("t4_settled_early", 32'(settled), 32'd0);
        @(negedge clk);
        check("t4_settled", 32'(settled), 32'd1);

        // Invalid selection
        #1 begin cfg_req = 1'b1; cfg_hpf_sel = 3'd6; cfg_lpf_en = 1'b1; end
        @(negedge clk);
        check("t3_err", 32'(cfg_err), 32'd1);
        check("t3_no_frst", 32'(filt_reset), 32'd0);
        check("t3_hpf", hpf_coefficient, 32'h0);
        check("t3_settled", 32'(settled), 32'd1);
        #1 cfg_req = 1'b0;
        @(negedge clk);
        check("t3_err_pulse", 32'(cfg_err), 32'd0);
        check("t3_settled_hold", 32'(settled), 32'd1);

        // Valid reconfiguration to 2.4 MHz with LPF
        #1 begin cfg_req = 1'b1; cfg_hpf_sel = 3'd4; cfg_lpf_en = 1'b1; end
        check("t2_ready", 32'(cfg_ready), 32'd1);
        @(negedge clk);
        check("t2_frst", 32'(filt_reset), 32'd1);
        check("t2_frst_settled", 32'(settled), 32'd0);
        #1 cfg_req = 1'b0;
        @(negedge clk);
        check("t2_ld0_hpf", hpf_coefficient, 32'h0000E546);
        check("t2_ld0_lpf", lpf_coefficient, 32'h0000001F);
        @(negedge clk);
        check("t2_ld1_hpf", hpf_coefficient, 32'hFFFF1ABA);
        check("t2_ld1_lpf", lpf_coefficient, 32'h0000001F);
        @(negedge clk);
        check("t2_ld2_hpf", hpf_coefficient, 32'h0000CA92);
        check("t2_ld2_lpf", lpf_coefficient, 32'h0000FFBE);
        @(negedge clk);
        check("t2_done", 32'(cfg_done), 32'd1);

        // Request raised mid-load is deferred; reset mid-load reloads defaults
        #1 begin cfg_req = 1'b1; cfg_hpf_sel = 3'd2; cfg_lpf_en = 1'b0; end
        @(negedge clk);
        #1 cfg_req = 1'b0;
        @(negedge clk);
        check("t5_ld0_hpf", hpf_coefficient, 32'h0000F9F5);
        @(negedge clk);
        #1 begin cfg_req = 1'b1; cfg_hpf_sel = 3'd3; cfg_lpf_en = 1'b1; end
        @(negedge clk);
        check("t5_ld2_ready", 32'(cfg_ready), 32'd0);
        check("t5_ld2_hpf", hpf_coefficient, 32'h0000F3EA);
        @(negedge clk);
        check("t5_done", 32'(cfg_done), 32'd1);
        check("t5_ready", 32'(cfg_ready), 32'd1);
        @(negedge clk);
        check("t5_frst", 32'(filt_reset), 32'd1);
        #1 cfg_req = 1'b0;
        @(negedge clk);
        check("t5_ld0_hpf3", hpf_coefficient, 32'h0000F168);
        check("t5_ld0_lpf", lpf_coefficient, 32'h0000001F);
        @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("t5_rst_frst", 32'(filt_reset), 32'd1);
        check("t5_rst_load", 32'(filt_load), 32'd0);
        #1 reset = 1'b0;
        @(negedge clk);
        check("t5_rst_hpf", hpf_coefficient, 32'h0000FF00);
        check("t5_rst_lpf", lpf_coefficient, 32'h0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #1;
            en = ($urandom_range(0, 9) < 7);
            reset = ($urandom_range(0, 499) == 0);
            if (!cfg_req) begin
                if ($urandom_range(0, 19) == 0) begin
                    cfg_req     = 1'b1;
                    cfg_hpf_sel = 3'($urandom_range(0, 7));
                    cfg_lpf_en  = 1'($urandom_range(0, 1));
                end
            end else if ($urandom_range(0, 2) == 0) begin
                cfg_req = 1'b0;
            end
        end
        @(negedge clk);
        #1 begin reset = 1'b0; cfg_req = 1'b0; end
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
